direction_input_ctrl: RTL and testbench
=======================================

// Module: direction_input_ctrl
// PURPOSE
//   Upstream input stage of the snake game. Turns the raw active-low KEY buttons into a registered
//   one-hot move direction for the snake datapath. Each button passes through a synchroniser, a
//   debouncer and a press-edge detector. Accepted turns go into a 2-entry FIFO and are applied one
//   per movement step, so a quick double turn (e.g. up then left) is not lost between steps.
// PARAMETERS
//   DEBOUNCE_CYCLES  500000  cycles a synced key must differ from its stable value before it is
//                            accepted (10 ms at 50 MHz); counter width is $clog2(DEBOUNCE_CYCLES+1)
// PORTS
//   clk           in   1  system clock (CLOCK_50)
//   resetn        in   1  synchronous, active-low reset
//   key_n         in   4  raw buttons, active-low: [3] left, [2] up, [1] down, [0] right
//   step          in   1  1-cycle pulse from the datapath when the head advances
//   move_left     out  1  one-hot current direction (registered)
//   move_up       out  1
//   move_down     out  1
//   move_right    out  1
//   dir           out  2  direction code: 00 right, 01 down, 10 up, 11 left
//   turn_taken    out  1  1-cycle pulse in the same cycle dir changes
//   dropped       out  1  1-cycle pulse when a valid turn is lost because the FIFO is full
// BEHAVIOUR
//   Reset (resetn=0 at posedge clk):
//     - dir=00, move_right=1, other move_* = 0; turn_taken=0, dropped=0.
//     - FIFO empty; sync flops and stable key values = 1 (released); debounce counters = 0.
//   Sync: two flops per key. A key change reaches the debouncer 2 cycles later.
//   Debounce, per key:
//     - synced==stable: counter <= 0.
//     - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, stable <= synced and
//       the counter clears. A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
//   Press event: stable 1->0 transition gives a 1-cycle pulse. Release makes no event.
//   Same-cycle events: priority up > down > left > right. Only the winner is evaluated; the
//     losers are discarded with no pulse.
//   Validity:
//     - Reference direction = FIFO tail entry if the FIFO is non-empty, else dir.
//     - A candidate on the same axis as the reference (same or opposite direction) is rejected.
//       It changes no state and gives no pulse.
//   Enqueue: a valid candidate is pushed 1 cycle after its press event.
//     - FIFO full and no pop in the same cycle: the candidate is discarded and dropped=1 that cycle.
//   Apply: on step with the FIFO non-empty:
//     - dir <= head, move_* <= decode(head), turn_taken=1 on the next cycle; head is popped.
//     - step with the FIFO empty: dir holds, no pulse.
//   Step and push in the same cycle:
//     - Pop and push both occur. Validity uses the reference from before the pop.
//     - When full, the pop frees a slot, so the push is accepted (no drop).
//     - A pushed entry is never applied by the step it coincides with; it waits for the next step.
//   Invariants:
//     - Exactly one move_* is high at all times after reset.
//     - dir changes only in the cycle after a step.
//     - FIFO occupancy is always 0..2.
//   Reset mid-operation clears pending turns at once. A key held through reset is seen as a new
//     press DEBOUNCE_CYCLES+2 cycles after release of reset (stable restarts at 1).
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//   1. Release reset, keys all 1 -> dir=00, move_right=1, turn_taken=0, dropped=0 for 20 cycles.
//   2. key_n[2]=0 for 3 cycles then 1 -> no enqueue. Hold for 10 cycles, then step ->
//      dir=10, move_up=1, turn_taken=1 for exactly 1 cycle.
//   3. dir=right, press left then step -> rejected; dir stays 00, turn_taken stays 0.
//      Press right -> also rejected.
//   4. dir=right, press up, then left, before any step -> two steps give dir=10 then dir=11,
//      one turn_taken pulse each.
//   5. dir=right, press up, left, down with no step -> dropped pulses once on the down press.
//      Three steps give 10, 11, then 11 (held, no pulse).
//   6. Up and right debounced in the same cycle -> only up is queued, no dropped pulse.
//      With the FIFO full, a push coinciding with step is accepted; occupancy stays 2.

Source files
------------

// File: rtl/direction_input_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : direction_input_ctrl_if
// Purpose  : Key/step inputs and direction outputs of the snake input stage.
// Revision : 1.0
// ============================================================================
interface direction_input_ctrl_if;
    logic [3:0] key_n;
    logic       step;
    logic       move_left;
    logic       move_up;
    logic       move_down;
    logic       move_right;
    logic [1:0] dir;
    logic       turn_taken;
    logic       dropped;

    modport slave (
        input  key_n, step,
        output move_left, move_up, move_down, move_right, dir, turn_taken, dropped
    );

    modport master (
        output key_n, step,
        input  move_left, move_up, move_down, move_right, dir, turn_taken, dropped
    );
endinterface
`default_nettype wire

// File: rtl/direction_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : direction_input_ctrl
// Purpose  : Debounced key presses -> validated turns -> 2-deep queue applied per step.
// Revision : 1.0
// ============================================================================
module direction_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  wire logic             clk,
    input  wire logic             resetn,
    direction_input_ctrl_if.slave bus
);
    localparam int              CW         = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   c_cnt_last = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]      c_dir_right = 2'b00;
    localparam logic [1:0]      c_dir_down  = 2'b01;
    localparam logic [1:0]      c_dir_up    = 2'b10;
    localparam logic [1:0]      c_dir_left  = 2'b11;

    logic [3:0] w_press;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            logic          r_sync1;
            logic          r_sync2;
            logic          r_stable;
            logic          r_stable_d;
            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_sync1    <= 1'b1;
                    r_sync2    <= 1'b1;
                    r_stable   <= 1'b1;
                    r_stable_d <= 1'b1;
                    r_cnt      <= '0;
                end else begin
                    r_sync1    <= bus.key_n[gi];
                    r_sync2    <= r_sync1;
                    r_stable_d <= r_stable;
                    if (r_sync2 == r_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_stable <= r_sync2;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            end

            // Only the falling (press) edge of the debounced level is an event.
            assign w_press[gi] = r_stable_d & ~r_stable;
        end
    endgenerate

    logic [1:0] w_win_dir;
    always_comb begin
        w_win_dir = c_dir_right;
        if (w_press[2])      w_win_dir = c_dir_up;
        else if (w_press[1]) w_win_dir = c_dir_down;
        else if (w_press[3]) w_win_dir = c_dir_left;
    end

    logic       r_cand_vld;
    logic [1:0] r_cand_dir;
    logic [1:0] r_fifo [2];
    logic       r_head;
    logic [1:0] r_count;
    logic [1:0] r_dir;
    logic [3:0] r_move;
    logic       r_turn;

    logic       w_tail_idx;
    logic       w_wr_idx;
    logic [1:0] w_ref;
    logic       w_clash;
    logic       w_pop;
    logic       w_valid;
    logic       w_push;

    // Write slot head^count[0] also lands in the slot freed by a pop when full.
    assign w_tail_idx = r_head ^ (r_count == 2'd2);
    assign w_wr_idx   = r_head ^ r_count[0];
    assign w_ref      = (r_count != 2'd0) ? r_fifo[w_tail_idx] : r_dir;
    assign w_clash    = (r_cand_dir[1] ^ r_cand_dir[0]) == (w_ref[1] ^ w_ref[0]);
    assign w_pop      = bus.step && (r_count != 2'd0);
    assign w_valid    = r_cand_vld && !w_clash;
    assign w_push     = w_valid && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cand_vld <= 1'b0;
            r_cand_dir <= c_dir_right;
            r_fifo[0]  <= c_dir_right;
            r_fifo[1]  <= c_dir_right;
            r_head     <= 1'b0;
            r_count    <= 2'd0;
            r_dir      <= c_dir_right;
            r_move     <= 4'b0001;
            r_turn     <= 1'b0;
        end else begin
            r_cand_vld <= |w_press;
            r_cand_dir <= w_win_dir;
            r_turn     <= w_pop;
            r_count    <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push) begin
                r_fifo[w_wr_idx] <= r_cand_dir;
            end
            if (w_pop) begin
                r_head <= ~r_head;
                r_dir  <= r_fifo[r_head];
                case (r_fifo[r_head])
                    c_dir_right: r_move <= 4'b0001;
                    c_dir_down:  r_move <= 4'b0010;
                    c_dir_up:    r_move <= 4'b0100;
                    default:     r_move <= 4'b1000;
                endcase
            end
        end
    end

    assign bus.dir        = r_dir;
    assign bus.move_left  = r_move[3];
    assign bus.move_up    = r_move[2];
    assign bus.move_down  = r_move[1];
    assign bus.move_right = r_move[0];
    assign bus.turn_taken = r_turn;
    assign bus.dropped    = w_valid && (r_count == 2'd2) && !w_pop;
endmodule
`default_nettype wire

// File: tb/tb_direction_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_direction_input_ctrl
// Purpose  : Scoreboard bench: turn-queue model predicts turn/drop pulses and direction.
// Revision : 1.0
// ============================================================================
module tb_direction_input_ctrl;
    localparam int DB = 4;
    localparam logic [1:0] RIGHT = 2'b00, DOWN = 2'b01, UP = 2'b10, LEFT = 2'b11;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    direction_input_ctrl_if bus();
    direction_input_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    typedef struct { bit is_drop; logic [1:0] d; } ev_t;
    ev_t        exp_q[$];
    logic [1:0] mdl_fifo[$];
    logic [1:0] mdl_dir;
    logic [1:0] mon_dir;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit horizontal(input logic [1:0] d);
        return (d == RIGHT) || (d == LEFT);
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] d);
        case (d)
            RIGHT:   return 4'b0001;
            DOWN:    return 4'b0010;
            UP:      return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    // Reference: one press event (mask of keys) and/or one step, applied at transaction level.
    task automatic mdl_event(input logic [3:0] mask, input bit step_too);
        logic [1:0] win, ref_d;
        bit valid = 1'b0;
        if (mask != 4'b0) begin
            win   = mask[2] ? UP : mask[1] ? DOWN : mask[3] ? LEFT : RIGHT;
            ref_d = (mdl_fifo.size() != 0) ? mdl_fifo[$] : mdl_dir;
            valid = horizontal(win) != horizontal(ref_d);
        end
        if (step_too && mdl_fifo.size() != 0) begin
            mdl_dir = mdl_fifo.pop_front();
            exp_q.push_back('{is_drop: 1'b0, d: mdl_dir});
        end
        if (valid) begin
            if (mdl_fifo.size() == 2) exp_q.push_back('{is_drop: 1'b1, d: 2'b00});
            else                      mdl_fifo.push_back(win);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_press(input logic [3:0] mask);
        mdl_event(mask, 1'b0);
        bus.key_n = ~mask;
        tick(10);
        bus.key_n = 4'hF;
        tick(12);
    endtask

    task automatic do_glitch(input logic [3:0] mask, input int len);
        bus.key_n = ~mask;
        tick(len);
        bus.key_n = 4'hF;
        tick(12);
    endtask

    task automatic do_step();
        mdl_event(4'b0, 1'b1);
        bus.step = 1'b1;
        tick(1);
        bus.step = 1'b0;
        tick(3);
    endtask

    // Step lands exactly in the cycle the press is pushed into the queue.
    task automatic do_press_with_step(input logic [3:0] mask);
        mdl_event(mask, 1'b1);
        bus.key_n = ~mask;
        tick(7);
        bus.step = 1'b1;
        tick(1);
        bus.step = 1'b0;
        tick(2);
        bus.key_n = 4'hF;
        tick(12);
    endtask

    task automatic reset_dut();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
        check("drain_before_reset", exp_q.size(), 0);
        exp_q.delete();
        resetn = 1'b0;
        tick(2);
        mdl_dir = RIGHT;
        mdl_fifo.delete();
        check("rst_dir", bus.dir, RIGHT);
        check("rst_move", {bus.move_left, bus.move_up, bus.move_down, bus.move_right}, 4'b0001);
        check("rst_turn_taken", bus.turn_taken, 1'b0);
        check("rst_dropped", bus.dropped, 1'b0);
        resetn = 1'b1;
        tick(2);
    endtask

    // Monitor: pops expected events whenever the DUT pulses, tracks the applied direction.
    initial begin
        ev_t e;
        mon_dir = RIGHT;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!resetn) begin
                mon_dir = RIGHT;
            end else begin
                if (bus.turn_taken) begin
                    check("turn_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("turn_kind", e.is_drop, 1'b0);
                        check("turn_dir", bus.dir, e.d);
                        mon_dir = e.d;
                    end
                end
                if (bus.dropped) begin
                    check("drop_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("drop_kind", e.is_drop, 1'b1);
                    end
                end
                check("dir_hold", bus.dir, mon_dir);
                check("move_onehot", {bus.move_left, bus.move_up, bus.move_down, bus.move_right},
                      onehot(mon_dir));
            end
        end
    end

    initial begin
        logic [3:0] m;
        int op;
        bus.key_n = 4'hF;
        bus.step  = 1'b0;
        mdl_dir   = RIGHT;
        tick(3);
        reset_dut();
        tick(20);

        // short glitch then a real up press, applied by a step
        do_glitch(4'b0100, 3);
        do_step();
        do_press(4'b0100);
        do_step();

        // same-axis turns rejected
        reset_dut();
        do_press(4'b1000);
        do_step();
        do_press(4'b0001);
        do_step();

        // quick double turn
        do_press(4'b0100);
        do_press(4'b1000);
        do_step();
        do_step();

        // third turn dropped while the queue is full
        reset_dut();
        do_press(4'b0100);
        do_press(4'b1000);
        do_press(4'b0010);
        do_step();
        do_step();
        do_step();

        // simultaneous press priority, then push coinciding with a step on a full queue
        reset_dut();
        do_press(4'b0101);
        do_press(4'b1000);
        do_press_with_step(4'b0010);
        do_step();
        do_step();
        do_step();

        // randomized mix
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 9);
            m  = 4'($urandom_range(1, 15));
            case (op)
                0, 1, 2, 3: do_press(4'b1 << $urandom_range(0, 3));
                4:          do_press(m);
                5:          do_glitch(m, $urandom_range(1, DB - 1));
                6, 7, 8:    do_step();
                default:    do_press_with_step(m);
            endcase
            if ($urandom_range(0, 29) == 0) reset_dut();
        end

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
        check("final_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
